// File: rtl/mem_region_controller_pkg.sv
// =============================================================================
// Module  : mem_region_controller_pkg
// Brief   : Region indices, FSM state encoding and select helper shared by the
//           memory region controller and its decoder.
// Rev     : 1.0 - initial release
// =============================================================================
`default_nettype none

package mem_region_controller_pkg;

  localparam logic [1:0] REG_ROM  = 2'd0;
  localparam logic [1:0] REG_IO   = 2'd1;
  localparam logic [1:0] REG_RAM  = 2'd2;
  localparam logic [1:0] REG_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // One-hot slave select ordered {ram, io, rom}.
  function automatic logic [2:0] region_sel(input logic [1:0] region);
    logic [2:0] sel;
    sel = 3'b000;
    case (region)
      REG_ROM: sel = 3'b001;
      REG_IO:  sel = 3'b010;
      REG_RAM: sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_region_controller_decode.sv
// =============================================================================
// Module  : mem_region_decode
// Brief   : Combinational hit/offset decode of a word address for one region.
// Rev     : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_region_decode #(
  parameter int                 ADDR_W = 16,
  parameter logic [ADDR_W-1:0]  BASE   = '0,
  parameter int                 AW     = 5
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [ADDR_W-1:0] offset
);

  localparam logic [ADDR_W-1:0] MASK = ADDR_W'((64'd1 << AW) - 64'd1);

  assign hit    = ((addr >> AW) == (BASE >> AW));
  assign offset = addr & MASK;

endmodule

`default_nettype wire

// File: rtl/mem_region_controller.sv
// =============================================================================
// Module  : mem_region_controller
// Brief   : Handshaked bus-to-slave controller decoding ROM / I/O / RAM regions
//           with per-region wait states, registered read data and bus errors.
// Rev     : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_region_controller
  import mem_region_controller_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  ROM_BASE = 16'h0000,
  parameter int                 ROM_AW   = 5,
  parameter logic [ADDR_W-1:0]  IO_BASE  = 16'h0020,
  parameter int                 IO_AW    = 5,
  parameter logic [ADDR_W-1:0]  RAM_BASE = 16'h0800,
  parameter int                 RAM_AW   = 11,
  parameter int                 ROM_WAIT = 0,
  parameter int                 IO_WAIT  = 1,
  parameter int                 RAM_WAIT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [2:0]        sel,
  output logic [ADDR_W-1:0] slv_addr,
  output logic [DATA_W-1:0] slv_wdata,
  output logic              slv_we,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic [DATA_W-1:0] io_rdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] C_ROM_WAIT = 4'(ROM_WAIT);
  localparam logic [3:0] C_IO_WAIT  = 4'(IO_WAIT);
  localparam logic [3:0] C_RAM_WAIT = 4'(RAM_WAIT);

  logic              rom_hit, io_hit, ram_hit;
  logic [ADDR_W-1:0] rom_off, io_off, ram_off;

  mem_region_decode #(.ADDR_W(ADDR_W), .BASE(ROM_BASE), .AW(ROM_AW)) u_dec_rom (
    .addr   (req_addr),
    .hit    (rom_hit),
    .offset (rom_off)
  );

  mem_region_decode #(.ADDR_W(ADDR_W), .BASE(IO_BASE), .AW(IO_AW)) u_dec_io (
    .addr   (req_addr),
    .hit    (io_hit),
    .offset (io_off)
  );

  mem_region_decode #(.ADDR_W(ADDR_W), .BASE(RAM_BASE), .AW(RAM_AW)) u_dec_ram (
    .addr   (req_addr),
    .hit    (ram_hit),
    .offset (ram_off)
  );

  // Overlapping ranges resolve ROM first, then I/O, then RAM.
  logic [1:0]        dec_region;
  logic [ADDR_W-1:0] dec_offset;
  logic [3:0]        dec_wait;

  always_comb begin
    dec_region = REG_NONE;
    dec_offset = '0;
    dec_wait   = 4'd0;
    if (rom_hit) begin
      dec_region = REG_ROM;
      dec_offset = rom_off;
      dec_wait   = C_ROM_WAIT;
    end else if (io_hit) begin
      dec_region = REG_IO;
      dec_offset = io_off;
      dec_wait   = C_IO_WAIT;
    end else if (ram_hit) begin
      dec_region = REG_RAM;
      dec_offset = ram_off;
      dec_wait   = C_RAM_WAIT;
    end
  end

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        region_q, region_d;
  logic              we_q, we_d;
  logic [2:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] slv_addr_q, slv_addr_d;
  logic [DATA_W-1:0] slv_wdata_q, slv_wdata_d;
  logic              slv_we_q, slv_we_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic [DATA_W-1:0] slave_rdata;

  always_comb begin
    slave_rdata = '0;
    case (region_q)
      REG_ROM: slave_rdata = rom_rdata;
      REG_IO:  slave_rdata = io_rdata;
      REG_RAM: slave_rdata = ram_rdata;
      default: slave_rdata = '0;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    region_d     = region_q;
    we_d         = we_q;
    sel_d        = sel_q;
    slv_addr_d   = slv_addr_q;
    slv_wdata_d  = slv_wdata_q;
    slv_we_d     = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if ((dec_region == REG_NONE) || (req_we && (dec_region == REG_ROM))) begin
            // Rejected accesses never touch a slave.
            state_d      = ST_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = ST_ACCESS;
            region_d    = dec_region;
            we_d        = req_we;
            sel_d       = region_sel(dec_region);
            slv_addr_d  = dec_offset;
            slv_wdata_d = req_wdata;
            slv_we_d    = req_we;
            cnt_d       = dec_wait;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          sel_d        = 3'b000;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? '0 : slave_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      region_q     <= REG_NONE;
      we_q         <= 1'b0;
      sel_q        <= 3'b000;
      slv_addr_q   <= '0;
      slv_wdata_q  <= '0;
      slv_we_q     <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      region_q     <= region_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      slv_addr_q   <= slv_addr_d;
      slv_wdata_q  <= slv_wdata_d;
      slv_we_q     <= slv_we_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign sel        = sel_q;
  assign slv_addr   = slv_addr_q;
  assign slv_wdata  = slv_wdata_q;
  assign slv_we     = slv_we_q;

endmodule

`default_nettype wire
